// File: rtl/memory_arbiter.sv
// memory_arbiter: shares the single RAM port between instruction fetch and
// data access. It holds each grant until RAM reports ACCESS, keeps a
// starvation counter so fetch cannot be locked out by data traffic, and
// resolves LL/SC locally through a one-entry link register.
module memory_arbiter #(
  parameter int WORD_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic              datomic,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IGNT   = 2'd1;
  localparam logic [1:0] DGNT   = 2'd2;
  localparam logic [1:0] SCFAIL = 2'd3;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]        state_reg, state_next;
  logic [3:0]        starve_cnt_reg, starve_cnt_next;
  logic              link_valid_reg, link_valid_next;
  logic [WORD_W-1:0] link_addr_reg, link_addr_next;

  logic ram_access;
  logic d_req;
  logic is_ll;
  logic is_sc;
  logic link_hit;
  logic i_done;
  logic d_done;
  logic sc_fail;

  assign ram_access = (ramstate == RAM_ACCESS);
  assign d_req      = dREN | dWEN;
  assign is_ll      = dREN & datomic;
  assign is_sc      = dWEN & datomic;
  assign link_hit   = link_valid_reg && (link_addr_reg == daddr);
  assign i_done     = (state_reg == IGNT) && ram_access;
  assign d_done     = (state_reg == DGNT) && ram_access;
  assign sc_fail    = (state_reg == SCFAIL);

  // Arbitration and grant sequencing; SC with a dead link skips the RAM entirely
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (iREN && (!d_req || starve_cnt_reg == STARVE_LIM)) begin
          state_next = IGNT;
        end else if (d_req) begin
          state_next = (is_sc && !link_hit) ? SCFAIL : DGNT;
        end
      end
      IGNT:    if (ram_access) state_next = IDLE;
      DGNT:    if (ram_access) state_next = IDLE;
      SCFAIL:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Count data completions that overtook a waiting fetch, saturating at the limit
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!iREN || i_done) begin
      starve_cnt_next = 4'd0;
    end else if ((d_done || sc_fail) && starve_cnt_reg < STARVE_LIM) begin
      starve_cnt_next = starve_cnt_reg + 4'd1;
    end
  end

  // Link register: set by LL, killed by any SC resolution or a plain store to the linked word
  always_comb begin
    link_valid_next = link_valid_reg;
    link_addr_next  = link_addr_reg;
    if (d_done) begin
      if (is_ll) begin
        link_valid_next = 1'b1;
        link_addr_next  = daddr;
      end else if (is_sc) begin
        link_valid_next = 1'b0;
      end else if (dWEN && daddr == link_addr_reg) begin
        link_valid_next = 1'b0;
      end
    end else if (sc_fail) begin
      link_valid_next = 1'b0;
    end
  end

  // State, counter and link registers; reset abandons any in-flight grant
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= 4'd0;
      link_valid_reg <= 1'b0;
      link_addr_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      link_valid_reg <= link_valid_next;
      link_addr_reg  <= link_addr_next;
    end
  end

  // RAM port drive depends only on the registered grant, never on ramstate
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_reg)
      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
      end
      DGNT: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      default: ;
    endcase
  end

  // Pipeline handshake: wait follows the request until its completion cycle
  always_comb begin
    iwait = iREN && !i_done;
    dwait = d_req && !d_done && !sc_fail;
    iload = i_done ? ramload : '0;
    dload = '0;
    if (d_done) begin
      dload = is_sc ? WORD_W'(1) : ramload;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: fetch path, priority, starvation
// limit, LL/SC link behaviour and asynchronous reset mid-grant.
module tb_memory_arbiter;

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, datomic;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_checks = 0;
  int n_pass   = 0;

  memory_arbiter #(.WORD_W(32), .STARVE_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issue one data request from IDLE and follow it to completion (bounded).
  task automatic data_txn(input logic ren, input logic wen, input logic at,
                          input logic [31:0] addr, input logic [31:0] store,
                          output logic [31:0] load, output logic wen_seen,
                          output logic [31:0] store_seen, output int cyc);
    dREN = ren; dWEN = wen; datomic = at; daddr = addr; dstore = store;
    ramstate = S_ACCESS;
    wen_seen = 1'b0; store_seen = '0; load = '0; cyc = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (ramWEN) begin wen_seen = 1'b1; store_seen = ramstore; end
      if (!dwait) begin load = dload; cyc = i; break; end
      step();
    end
    step();
    dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0;
    $display("txn data ren=%0d wen=%0d atomic=%0d addr=%h load=%h ramWEN_seen=%0d cycles=%0d",
             ren, wen, at, addr, load, wen_seen, cyc);
  endtask

  task automatic test_reset();
    nRST = 1'b0; iREN = 1'b1; dWEN = 1'b1; ramstate = S_ACCESS; ramload = 32'hFFFF_FFFF;
    iaddr = 32'h44; daddr = 32'h88; dstore = 32'h99;
    @(negedge CLK);
    n_checks++; if (iwait !== 1'b1) $display("FAIL rst_iwait: got %h want 1", iwait); else n_pass++;
    n_checks++; if (dwait !== 1'b1) $display("FAIL rst_dwait: got %h want 1", dwait); else n_pass++;
    n_checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) $display("FAIL rst_strobes: got %b%b want 00", ramREN, ramWEN); else n_pass++;
    n_checks++; if (ramaddr !== 32'h0) $display("FAIL rst_ramaddr: got %h want 0", ramaddr); else n_pass++;
    n_checks++; if (ramstore !== 32'h0) $display("FAIL rst_ramstore: got %h want 0", ramstore); else n_pass++;
    n_checks++; if (iload !== 32'h0 || dload !== 32'h0) $display("FAIL rst_loads: got %h/%h want 0/0", iload, dload); else n_pass++;
    iREN = 1'b0; dWEN = 1'b0;
    #1;
    n_checks++; if (iwait !== 1'b0 || dwait !== 1'b0) $display("FAIL rst_idle_waits: got %b%b want 00", iwait, dwait); else n_pass++;
    @(negedge CLK);
    nRST = 1'b1;
    step();
    $display("txn reset released");
  endtask

  task automatic test_ifetch();
    iREN = 1'b1; iaddr = 32'h40; ramstate = S_ACCESS; ramload = 32'h8C22_0004;
    @(negedge CLK);
    n_checks++; if (ramREN !== 1'b0) $display("FAIL if_idle_ramREN: got %h want 0", ramREN); else n_pass++;
    n_checks++; if (iwait !== 1'b1) $display("FAIL if_idle_iwait: got %h want 1", iwait); else n_pass++;
    step();
    @(negedge CLK);
    n_checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0) $display("FAIL if_grant_strobes: got %b%b want 10", ramREN, ramWEN); else n_pass++;
    n_checks++; if (ramaddr !== 32'h40) $display("FAIL if_ramaddr: got %h want 00000040", ramaddr); else n_pass++;
    n_checks++; if (iwait !== 1'b0) $display("FAIL if_iwait_done: got %h want 0", iwait); else n_pass++;
    n_checks++; if (iload !== 32'h8C22_0004) $display("FAIL if_iload: got %h want 8c220004", iload); else n_pass++;
    step();
    iREN = 1'b0;
    @(negedge CLK);
    n_checks++; if (ramREN !== 1'b0) $display("FAIL if_back_idle: got %h want 0", ramREN); else n_pass++;
    $display("txn ifetch addr=00000040 load=%h", 32'h8C22_0004);
    step();
  endtask

  task automatic test_priority();
    iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; daddr = 32'h100;
    ramstate = S_BUSY; ramload = 32'hDEAD_0100;
    @(negedge CLK);
    n_checks++; if (iwait !== 1'b1 || dwait !== 1'b1) $display("FAIL pr_idle_waits: got %b%b want 11", iwait, dwait); else n_pass++;
    step();
    @(negedge CLK);
    n_checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100) $display("FAIL pr_data_first: got %b/%h want 1/00000100", ramREN, ramaddr); else n_pass++;
    n_checks++; if (dwait !== 1'b1 || iwait !== 1'b1) $display("FAIL pr_busy1_waits: got %b%b want 11", dwait, iwait); else n_pass++;
    step();
    @(negedge CLK);
    n_checks++; if (ramaddr !== 32'h100 || dwait !== 1'b1 || dload !== 32'h0) $display("FAIL pr_busy2_hold: got %h/%b/%h want 00000100/1/0", ramaddr, dwait, dload); else n_pass++;
    step();
    ramstate = S_ACCESS;
    @(negedge CLK);
    n_checks++; if (dwait !== 1'b0 || dload !== 32'hDEAD_0100) $display("FAIL pr_data_done: got %b/%h want 0/dead0100", dwait, dload); else n_pass++;
    n_checks++; if (iwait !== 1'b1) $display("FAIL pr_iwait_held: got %h want 1", iwait); else n_pass++;
    $display("txn data read addr=00000100 load=%h", dload);
    step();
    dREN = 1'b0;
    @(negedge CLK);
    n_checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) $display("FAIL pr_bubble: got %b/%b want 0/1", ramREN, iwait); else n_pass++;
    step();
    @(negedge CLK);
    n_checks++; if (ramaddr !== 32'h40 || iwait !== 1'b0 || iload !== 32'hDEAD_0100) $display("FAIL pr_instr_after: got %h/%b/%h want 00000040/0/dead0100", ramaddr, iwait, iload); else n_pass++;
    $display("txn ifetch addr=00000040 load=%h", iload);
    step();
    iREN = 1'b0;
    step();
  endtask

  task automatic test_starve();
    logic [31:0] grants [6];
    logic [31:0] exp_g  [6];
    int ng = 0;
    exp_g = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h40, 32'h100};
    for (int k = 0; k < 6; k++) grants[k] = '0;
    iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; daddr = 32'h100;
    ramstate = S_ACCESS; ramload = 32'h0;
    for (int i = 0; i < 40 && ng < 6; i++) begin
      @(negedge CLK);
      if (ramREN) begin
        grants[ng] = ramaddr;
        $display("txn starve grant %0d addr=%h", ng, ramaddr);
        ng++;
      end
      if (ng < 6) step();
    end
    step();
    iREN = 1'b0; dREN = 1'b0;
    n_checks++; if (ng !== 6) $display("FAIL st_grant_count: got %0d want 6", ng); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (grants[k] !== exp_g[k]) $display("FAIL st_grant%0d: got %h want %h", k, grants[k], exp_g[k]);
      else n_pass++;
    end
    step();
  endtask

  task automatic test_ll_sc();
    logic [31:0] ld, st;
    logic we;
    int cyc;
    ramload = 32'hABCD_0000;
    data_txn(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, ld, we, st, cyc);
    n_checks++; if (ld !== 32'hABCD_0000 || cyc !== 1) $display("FAIL ll_load: got %h/%0d want abcd0000/1", ld, cyc); else n_pass++;
    ramload = 32'h55;
    data_txn(1'b0, 1'b1, 1'b1, 32'h200, 32'h7, ld, we, st, cyc);
    n_checks++; if (we !== 1'b1 || st !== 32'h7) $display("FAIL sc_ram_write: got %b/%h want 1/00000007", we, st); else n_pass++;
    n_checks++; if (ld !== 32'h1 || cyc !== 1) $display("FAIL sc_success: got %h/%0d want 00000001/1", ld, cyc); else n_pass++;
    data_txn(1'b0, 1'b1, 1'b1, 32'h200, 32'h8, ld, we, st, cyc);
    n_checks++; if (ld !== 32'h0) $display("FAIL sc2_result: got %h want 0", ld); else n_pass++;
    n_checks++; if (we !== 1'b0) $display("FAIL sc2_no_write: got %h want 0", we); else n_pass++;
    n_checks++; if (cyc !== 1) $display("FAIL sc2_latency: got %0d want 1", cyc); else n_pass++;
  endtask

  task automatic test_sw_invalidate();
    logic [31:0] ld, st;
    logic we;
    int cyc;
    ramload = 32'h55;
    data_txn(1'b1, 1'b0, 1'b1, 32'h200, 32'h0,  ld, we, st, cyc);
    data_txn(1'b0, 1'b1, 1'b0, 32'h200, 32'h11, ld, we, st, cyc);
    n_checks++; if (we !== 1'b1 || st !== 32'h11) $display("FAIL sw_write: got %b/%h want 1/00000011", we, st); else n_pass++;
    data_txn(1'b0, 1'b1, 1'b1, 32'h200, 32'h7,  ld, we, st, cyc);
    n_checks++; if (ld !== 32'h0 || we !== 1'b0) $display("FAIL sc_after_sw_same: got %h/%b want 0/0", ld, we); else n_pass++;
    data_txn(1'b1, 1'b0, 1'b1, 32'h200, 32'h0,  ld, we, st, cyc);
    data_txn(1'b0, 1'b1, 1'b0, 32'h204, 32'h22, ld, we, st, cyc);
    data_txn(1'b0, 1'b1, 1'b1, 32'h200, 32'h9,  ld, we, st, cyc);
    n_checks++; if (ld !== 32'h1 || we !== 1'b1) $display("FAIL sc_after_sw_other: got %h/%b want 1/1", ld, we); else n_pass++;
    n_checks++; if (st !== 32'h9) $display("FAIL sc_other_store: got %h want 00000009", st); else n_pass++;
  endtask

  task automatic test_reset_midgrant();
    logic [31:0] ld, st;
    logic we;
    int cyc;
    ramload = 32'h0;
    data_txn(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, ld, we, st, cyc);
    dREN = 1'b1; daddr = 32'h300; ramstate = S_BUSY; ramload = 32'h3000;
    @(negedge CLK);
    step();
    @(negedge CLK);
    n_checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h300) $display("FAIL rm_granted: got %b/%h want 1/00000300", ramREN, ramaddr); else n_pass++;
    #2 nRST = 1'b0;
    #1;
    n_checks++; if (ramREN !== 1'b0 || ramaddr !== 32'h0) $display("FAIL rm_strobe_drop: got %b/%h want 0/0", ramREN, ramaddr); else n_pass++;
    n_checks++; if (dwait !== 1'b1) $display("FAIL rm_dwait: got %h want 1", dwait); else n_pass++;
    ramstate = S_ACCESS;
    @(negedge CLK);
    #1 nRST = 1'b1;
    @(negedge CLK);
    n_checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h300) $display("FAIL rm_rearb: got %b/%h want 1/00000300", ramREN, ramaddr); else n_pass++;
    n_checks++; if (dwait !== 1'b0 || dload !== 32'h3000) $display("FAIL rm_done: got %b/%h want 0/00003000", dwait, dload); else n_pass++;
    $display("txn data read after reset addr=00000300 load=%h", dload);
    step();
    dREN = 1'b0;
    data_txn(1'b0, 1'b1, 1'b1, 32'h200, 32'h5, ld, we, st, cyc);
    n_checks++; if (ld !== 32'h0 || we !== 1'b0) $display("FAIL rm_link_cleared: got %h/%b want 0/0", ld, we); else n_pass++;
  endtask

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = S_FREE;
    test_reset();
    test_ifetch();
    test_priority();
    test_starve();
    test_ll_sc();
    test_sw_invalidate();
    test_reset_midgrant();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
